// File: rtl/seq_signed_divider_pkg.sv
// Shared ALU divide-path definitions: width, FSM states and result constants.
package seq_signed_divider_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ITER  = 2'd2,
    FIXUP = 2'd3
  } div_state_e;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INT_MIN       = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_signed_divider_if.sv
// Divide request/result bundle between the ALU operand logic and the divider.
//
// Handshake: start is a request that the divider samples only while idle; the
// edge that accepts it raises busy, and operands are captured on that same
// edge. busy stays high until the edge that raises done, which is a one-cycle
// pulse; quotient, remainder and div_by_zero are valid from the done cycle and
// hold until the next done. There is no ready/backpressure on the result side.
interface seq_signed_divider_if;
  import seq_signed_divider_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_signed_divider_magnitude_negate.sv
// Combinational two's-complement negation, used for magnitudes and sign restore.
module magnitude_negate
  import seq_signed_divider_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Invert and add one; 0x80000000 maps onto itself, which is the wanted magnitude.
  assign y = ~a + ONE;

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: magnitudes in, one restoring step per clock,
// signs restored at the end, results held until the next divide completes.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  seq_signed_divider_if.slave  bus,
  output div_state_e           dbg_state
);

  div_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic [WIDTH-1:0] neg_op_a, neg_op_y;
  logic [WIDTH-1:0] neg_res_y;
  logic [WIDTH:0]   trial;

  // Operand negator: dividend while accepting, divisor in LOAD, remainder in FIXUP.
  always_comb begin
    neg_op_a = '0;
    case (state_q)
      IDLE:    neg_op_a = bus.dividend;
      LOAD:    neg_op_a = divisor_q;
      FIXUP:   neg_op_a = rem_q;
      default: neg_op_a = '0;
    endcase
  end

  magnitude_negate u_neg_op (
    .a (neg_op_a),
    .y (neg_op_y)
  );

  magnitude_negate u_neg_res (
    .a (quo_q),
    .y (neg_res_y)
  );

  // Restoring trial subtraction on the shifted partial remainder, one bit wider.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dmag_q};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    dmag_d      = dmag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    count_d     = count_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          // Dividend magnitude is taken here so the single operand negator can
          // serve the divisor in LOAD.
          quo_d      = bus.dividend[WIDTH-1] ? neg_op_y : bus.dividend;
          busy_d     = 1'b1;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        neg_quo_d = dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
        neg_rem_d = dividend_q[WIDTH-1];
        dmag_d    = divisor_q[WIDTH-1] ? neg_op_y : divisor_q;
        rem_d     = '0;
        count_d   = '0;
        state_d   = ITER;
      end

      ITER: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        if (divisor_q == '0) begin
          quotient_d  = DIV0_QUOTIENT;
          remainder_d = dividend_q;
          dbz_d       = 1'b1;
        end else begin
          // INT_MIN / -1 needs no special case: -0x80000000 wraps to itself.
          quotient_d  = neg_quo_q ? neg_res_y : quo_q;
          remainder_d = neg_rem_q ? neg_op_y : rem_q;
          dbz_d       = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      dmag_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      count_q     <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      dmag_q      <= dmag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      count_q     <= count_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: vector table, corner sequences, random vs. model.
module tb_seq_signed_divider;
  import seq_signed_divider_pkg::*;

  localparam int LAT = WIDTH + 2;

  logic       clk;
  logic       rst_n;
  div_state_e dbg_state;

  seq_signed_divider_if bus ();

  seq_signed_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
  } vec_t;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic; SV division truncates toward zero and
  // the remainder follows the dividend, matching the required rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = DIV0_QUOTIENT;
      r = a;
      z = 1'b1;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      z  = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after the accepting edge; returns edges counted to done (-1 on timeout).
  task automatic wait_done(input bit hold, input bit disturb,
                           output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      bus.start = hold;
      if (disturb) begin
        bus.dividend = $urandom;
        bus.divisor  = $urandom_range(1, 50);
        if (k == 5) bus.start = 1'b1;
      end
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit disturb,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    wait_done(1'b0, disturb, lat, busy_ok);
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    bus.start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eq, input logic [31:0] er, input logic ez);
    logic [31:0] q, r;
    logic        z;
    int          lat;
    bit          bok;
    do_div(a, b, 1'b0, q, r, z, lat, bok);
    check({tag, "_quotient"}, q, eq);
    check({tag, "_remainder"}, r, er);
    check({tag, "_div_by_zero"}, {31'd0, z}, {31'd0, ez});
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_busy_span"}, {31'd0, bok}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t        vecs[10];
    logic [31:0] q, r, eq, er, a, b;
    logic        z, ez;
    int          lat, dones, mode;
    bit          bok;

    vecs[0] = '{32'd100,      32'd7,          32'h0000000E, 32'h00000002, 1'b0};
    vecs[1] = '{32'hFFFFFF9C, 32'h00000007,   32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2] = '{32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2, 32'h00000002, 1'b0};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001,   32'h80000000, 32'h00000000, 1'b0};
    vecs[5] = '{32'd5,        32'd0,          32'hFFFFFFFF, 32'h00000005, 1'b1};
    vecs[6] = '{32'd9,        32'd3,          32'h00000003, 32'h00000000, 1'b0};
    vecs[7] = '{32'hFFFFFFF9, 32'd0,          32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000,   32'h00000000, 32'h7FFFFFFF, 1'b0};
    vecs[9] = '{32'h80000000, 32'h80000000,   32'h00000001, 32'h00000000, 1'b0};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_quotient", bus.quotient, 32'd0);
    check("reset_remainder", bus.remainder, 32'd0);
    check("reset_div_by_zero", {31'd0, bus.div_by_zero}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].eq, vecs[i].er, vecs[i].ez);
    end

    // Restart and operand changes while busy are ignored; single done pulse.
    do_div(32'd100, 32'd7, 1'b1, q, r, z, lat, bok);
    bus.dividend = '0;
    bus.divisor  = '0;
    check("disturb_quotient", q, 32'h0000000E);
    check("disturb_remainder", r, 32'h00000002);
    check("disturb_latency", lat, LAT);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("disturb_extra_done", dones, 0);

    // Back-to-back with start held high through done.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    wait_done(1'b1, 1'b0, lat, bok);
    check("b2b_first_quotient", bus.quotient, 32'h0000000E);
    check("b2b_first_latency", lat, LAT);
    check("b2b_done_state", {30'd0, dbg_state}, {30'd0, IDLE});
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    @(posedge clk);
    #1;
    check("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(1'b0, 1'b0, lat, bok);
    check("b2b_second_quotient", bus.quotient, 32'h00000003);
    check("b2b_second_remainder", bus.remainder, 32'h00000000);
    check("b2b_second_latency", lat, LAT);
    bus.start = 1'b0;

    // Reset mid-ITER aborts the divide.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_pre_state", {30'd0, dbg_state}, {30'd0, ITER});
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    check("midreset_quotient", bus.quotient, 32'd0);
    check("midreset_remainder", bus.remainder, 32'd0);
    check("midreset_state", {30'd0, dbg_state}, {30'd0, IDLE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midreset_no_done", dones, 0);
    run_and_check("post_reset", 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);

    // Randomized divides against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case (mode)
        0: b = 32'd0;
        1: a = INT_MIN;
        2, 3: begin
          b = $urandom_range(1, 16);
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      ref_div(a, b, eq, er, ez);
      run_and_check($sformatf("rand%0d", i), a, b, eq, er, ez);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
